mem64x8_arbiter: RTL and testbench

- Shares the single-port 64x8 memory array between two requesters.
  - Port A: the mprj_io pin interface (external tester).
  - Port B: the on-chip host (Wishbone/LA bridge).
- Optionally clears every memory location after reset, then arbitrates round-robin.
- Issues one-cycle rd_en/wr_en strobes to the array and returns read data with a per-port ack pulse.
- Sits between the IO/host front-ends and the memory macro inside the user project area.

---
 rtl/mem64x8_arbiter_pkg.sv | 23 ++
 rtl/mem64x8_arbiter_if.sv | 51 +++++
 rtl/mem64x8_arbiter_rr_arb2.sv | 28 ++
 rtl/mem64x8_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem64x8_arbiter.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem64x8_arbiter_pkg.sv
// Shared types and constants for the 64x8 memory arbiter slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem64x8_arb_pkg;

  localparam int unsigned ADDR_W = 6;  // 64 words
  localparam int unsigned DATA_W = 8;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_RWAIT = 3'd3,
    ST_ACK   = 3'd4
  } state_t;

  // Port select; also the bit index of each port in req/grant vectors.
  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_t;

endpackage

// File: rtl/mem64x8_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the 64x8 array.
// Latency: n/a (wires only).
// Backpressure: req held until the one-cycle ack; the array side has none.
// Ports: a_*/b_* requester handshakes, mem_* array strobes/data, init_done.
//   slave  = arbiter view, master = requester/array view.
interface mem64x8_arbiter_if;
  import mem64x8_arb_pkg::*;

  logic              a_req;
  logic              a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic              a_ack;
  logic [DATA_W-1:0] a_rdata;

  logic              b_req;
  logic              b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic              b_ack;
  logic [DATA_W-1:0] b_rdata;

  logic              mem_rd_en;
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              init_done;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    output a_ack, a_rdata,
    input  b_req, b_we, b_addr, b_wdata,
    output b_ack, b_rdata,
    output mem_rd_en, mem_wr_en, mem_addr, mem_wdata,
    input  mem_rdata,
    output init_done
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    input  a_ack, a_rdata,
    output b_req, b_we, b_addr, b_wdata,
    input  b_ack, b_rdata,
    input  mem_rd_en, mem_wr_en, mem_addr, mem_wdata,
    output mem_rdata,
    input  init_done
  );

endinterface

// File: rtl/mem64x8_arbiter_rr_arb2.sv
// Two-requester round-robin grant, combinational.
// Latency: 0 cycles (grant valid in the same cycle as req).
// Backpressure: grant forced to zero while en_i is low.
// Ports: req_i[1:0] (index = port_t), last_i = last granted port,
//   en_i = grant enable, gnt_o[1:0] one-hot grant.
module rr_arb2
  import mem64x8_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  port_t      last_i,
  input  logic       en_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    if (en_i) begin
      if (&req_i) begin
        // Contention: the port that did not win last time goes next.
        gnt_o = (last_i == PORT_A) ? 2'b10 : 2'b01;
      end else begin
        // Zero or one request: the request vector already is the grant.
        gnt_o = req_i;
      end
    end
  end

endmodule

// File: rtl/mem64x8_arbiter.sv
// Shares a single-port 64x8 array between port A (pins) and port B (host).
// Latency from the granting edge: write ack +2, read ack +3; strobe at +1.
// Backpressure: requesters hold req until ack; no grant during the init sweep.
// Ports: clock, resetb (async, active low), bus (slave modport: a_*/b_*
//   handshakes, mem_* array interface, init_done). Widths come from the package.
module mem64x8_arbiter
  import mem64x8_arb_pkg::*;
#(
  parameter bit                INIT_EN  = 1'b1,
  parameter logic [DATA_W-1:0] INIT_VAL = 8'h00
) (
  input  logic               clock,
  input  logic               resetb,
  mem64x8_arbiter_if.slave   bus
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  port_t             last_q, last_d;
  port_t             sel_q, sel_d;
  logic              we_q, we_d;
  logic              rd_en_q, rd_en_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
  logic [DATA_W-1:0] b_rdata_q, b_rdata_d;
  logic              a_ack_q, a_ack_d;
  logic              b_ack_q, b_ack_d;
  logic              done_q, done_d;
  logic [1:0]        gnt;

  rr_arb2 u_arb (
    .req_i  ({bus.b_req, bus.a_req}),
    .last_i (last_q),
    .en_i   (state_q == ST_IDLE),
    .gnt_o  (gnt)
  );

  // Every output is a register loaded from next-state values, so the strobe
  // is visible during the ISSUE state and the ack during the ACK state.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    sel_d     = sel_q;
    we_d      = we_q;
    rd_en_d   = 1'b0;
    wr_en_d   = 1'b0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    a_ack_d   = 1'b0;
    b_ack_d   = 1'b0;
    done_d    = done_q;

    case (state_q)
      ST_INIT: begin
        wr_en_d = 1'b1;
        addr_d  = cnt_q;
        wdata_d = INIT_VAL;
        cnt_d   = cnt_q + ADDR_W'(1);
        if (&cnt_q) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      ST_IDLE: begin
        if (|gnt) begin
          // Latch the winner's command here; later input changes are ignored
          // because addr_q/wdata_q/we_q hold it for the whole transaction.
          sel_d   = gnt[PORT_B] ? PORT_B : PORT_A;
          last_d  = sel_d;
          we_d    = gnt[PORT_B] ? bus.b_we    : bus.a_we;
          addr_d  = gnt[PORT_B] ? bus.b_addr  : bus.a_addr;
          wdata_d = gnt[PORT_B] ? bus.b_wdata : bus.a_wdata;
          wr_en_d = we_d;
          rd_en_d = ~we_d;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (we_q) begin
          a_ack_d = (sel_q == PORT_A);
          b_ack_d = (sel_q == PORT_B);
          state_d = ST_ACK;
        end else begin
          state_d = ST_RWAIT;
        end
      end
      ST_RWAIT: begin
        // Array data is valid the cycle after the read strobe, i.e. now.
        if (sel_q == PORT_A) a_rdata_d = bus.mem_rdata;
        else                 b_rdata_d = bus.mem_rdata;
        a_ack_d = (sel_q == PORT_A);
        b_ack_d = (sel_q == PORT_B);
        state_d = ST_ACK;
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_q   <= INIT_EN ? ST_INIT : ST_IDLE;
      cnt_q     <= '0;
      last_q    <= PORT_B;  // so port A wins the first contention
      sel_q     <= PORT_A;
      we_q      <= 1'b0;
      rd_en_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
      a_ack_q   <= 1'b0;
      b_ack_q   <= 1'b0;
      done_q    <= ~INIT_EN;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      sel_q     <= sel_d;
      we_q      <= we_d;
      rd_en_q   <= rd_en_d;
      wr_en_q   <= wr_en_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
      a_ack_q   <= a_ack_d;
      b_ack_q   <= b_ack_d;
      done_q    <= done_d;
    end
  end

  assign bus.a_ack     = a_ack_q;
  assign bus.a_rdata   = a_rdata_q;
  assign bus.b_ack     = b_ack_q;
  assign bus.b_rdata   = b_rdata_q;
  assign bus.mem_rd_en = rd_en_q;
  assign bus.mem_wr_en = wr_en_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.init_done = done_q;

endmodule

// File: tb/tb_mem64x8_arbiter.sv
// Self-checking bench for mem64x8_arbiter with a behavioural memory model.
// Latency: checks write ack at +2 and read ack at +3 from the sampling edge.
// Backpressure: requesters hold req until ack, as the DUT expects.
module tb_mem64x8_arbiter;
  import mem64x8_arb_pkg::*;

  localparam logic [7:0] INIT_V = 8'hA5;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  mem64x8_arbiter_if bus ();

  mem64x8_arbiter #(
    .INIT_EN  (1'b1),
    .INIT_VAL (INIT_V)
  ) dut (
    .clock  (clk),
    .resetb (rst_n),
    .bus    (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // The memory macro itself: registered read, data valid the cycle after rd_en.
  logic [7:0] mac_mem [64];
  always @(posedge clk) begin
    if (bus.mem_wr_en) mac_mem[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_rd_en) bus.mem_rdata <= mac_mem[bus.mem_addr];
  end

  // Reference model: transactions apply atomically, in ack order.
  logic [7:0] ref_mem [64];
  logic [7:0] exp_rd  [2];
  bit         pend_we [2];
  logic [5:0] pend_addr [2];
  logic [7:0] pend_wd [2];
  int         ack_log [$];
  int         overlap_cnt = 0;
  bit         stb_we;
  logic [5:0] stb_addr;
  logic [7:0] stb_wd;

  task automatic score(input int p);
    if (pend_we[p]) ref_mem[pend_addr[p]] = pend_wd[p];
    else            exp_rd[p] = ref_mem[pend_addr[p]];
    chk("strobe_we", stb_we, pend_we[p]);
    chk("strobe_addr", stb_addr, pend_addr[p]);
    if (pend_we[p]) chk("strobe_wdata", stb_wd, pend_wd[p]);
    chk("a_rdata", bus.a_rdata, exp_rd[0]);
    chk("b_rdata", bus.b_rdata, exp_rd[1]);
    ack_log.push_back(p);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.mem_rd_en && bus.mem_wr_en) overlap_cnt++;
      if (bus.a_ack && bus.b_ack) overlap_cnt++;
      if (bus.init_done && (bus.mem_rd_en || bus.mem_wr_en)) begin
        stb_we   = bus.mem_wr_en;
        stb_addr = bus.mem_addr;
        stb_wd   = bus.mem_wdata;
      end
      if (bus.a_ack) score(0);
      if (bus.b_ack) score(1);
    end
  end

  task automatic drive(input int p, input bit r, input bit we, input logic [5:0] a, input logic [7:0] d);
    if (p == 0) begin
      bus.a_req = r; bus.a_we = we; bus.a_addr = a; bus.a_wdata = d;
    end else begin
      bus.b_req = r; bus.b_we = we; bus.b_addr = a; bus.b_wdata = d;
    end
  endtask

  // One request on port p; lat = negedges from req assertion until ack seen.
  task automatic xact(input int p, input bit we, input logic [5:0] addr, input logic [7:0] wd,
                      input bit perturb, output int lat);
    bit got;
    pend_we[p] = we; pend_addr[p] = addr; pend_wd[p] = wd;
    drive(p, 1'b1, we, addr, wd);
    got = 1'b0;
    lat = 0;
    for (int k = 1; k <= 300 && !got; k++) begin
      @(negedge clk);
      #1;
      if (perturb && k == 1) drive(p, 1'b1, we, ~addr, ~wd);
      if ((p == 0 && bus.a_ack) || (p == 1 && bus.b_ack)) begin
        got = 1'b1;
        lat = k;
      end
    end
    drive(p, 1'b0, we, addr, wd);
    chk("ack_seen", got, 1);
  endtask

  // Holds reset low, checks every output is zero, resets the model.
  task automatic apply_reset();
    rst_n = 1'b0;
    foreach (ref_mem[i]) ref_mem[i] = INIT_V;
    exp_rd[0] = 8'h00;
    exp_rd[1] = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_ctl", {bus.a_ack, bus.b_ack, bus.mem_rd_en, bus.mem_wr_en, bus.init_done}, 0);
    chk("reset_data", {bus.a_rdata, bus.b_rdata, bus.mem_addr, bus.mem_wdata}, 0);
  endtask

  // Call at the negedge where reset is released.
  task automatic check_init_sweep(input string tag);
    int n;
    int bad;
    bit done;
    n = 0; bad = 0; done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (bus.mem_wr_en) begin
        if (bus.mem_addr != n[5:0] || bus.mem_wdata != INIT_V) bad++;
        n++;
      end else if (n > 0) begin
        bad++;  // gap inside the sweep
      end
      if (bus.mem_rd_en) bad++;
      if (bus.init_done) done = 1'b1;
    end
    chk({tag, "_done"}, done, 1);
    chk({tag, "_count"}, n, 64);
    chk({tag, "_seq"}, bad, 0);
  endtask

  int la, lb, base, last_p, exp_p, m;
  bit wa, wb;
  logic [5:0] aa, ab;
  logic [7:0] da, db;

  initial begin
    drive(0, 1'b0, 1'b0, 6'h00, 8'h00);
    drive(1, 1'b0, 1'b0, 6'h00, 8'h00);
    #2;
    apply_reset();

    // Both ports request from reset; A must win after the sweep.
    base = ack_log.size();
    fork
      begin rst_n = 1'b1; check_init_sweep("init"); end
      xact(0, 1'b1, 6'h18, 8'hEA, 1'b0, la);
      xact(1, 1'b0, 6'h18, 8'h00, 1'b0, lb);
    join
    chk("reset_ack_count", ack_log.size() - base, 2);
    chk("reset_first_winner", ack_log[base], 0);
    chk("reset_second_winner", ack_log[base + 1], 1);
    chk("b_read_after_a_write", bus.b_rdata, 8'hEA);

    // Initialised content.
    xact(0, 1'b0, 6'd17, 8'h00, 1'b0, la);
    chk("init_value_read", bus.a_rdata, INIT_V);

    // Latencies from an idle start.
    @(negedge clk);
    xact(0, 1'b1, 6'b111001, 8'hFA, 1'b0, la);
    chk("write_latency", la, 2);
    @(negedge clk);
    xact(0, 1'b0, 6'b111001, 8'h00, 1'b0, la);
    chk("read_latency", la, 3);
    chk("read_back", bus.a_rdata, 8'hFA);
    // Requested during the ACK cycle: picked up at the following IDLE.
    xact(1, 1'b1, 6'h02, 8'h3C, 1'b0, lb);
    chk("ack_cycle_req_latency", lb, 3);

    // Continuous contention: service alternates starting with the other port.
    last_p = ack_log[ack_log.size() - 1];
    base = ack_log.size();
    fork
      begin
        for (int i = 0; i < 2; i++) xact(0, 1'b1, 6'h20, 8'h11 + 8'(i), 1'b0, la);
      end
      begin
        for (int j = 0; j < 2; j++) xact(1, 1'b0, 6'h20, 8'h00, 1'b0, lb);
      end
    join
    chk("alt_count", ack_log.size() - base, 4);
    exp_p = 1 - last_p;
    for (int i = 0; i < 4; i++) begin
      chk("alt_order", ack_log[base + i], exp_p);
      exp_p = 1 - exp_p;
    end

    // Inputs changed after the grant edge must not reach the array.
    @(negedge clk);
    xact(0, 1'b1, 6'h0A, 8'h5D, 1'b1, la);
    xact(0, 1'b0, 6'h0A, 8'h00, 1'b0, la);
    chk("latched_write_data", bus.a_rdata, 8'h5D);
    xact(0, 1'b0, 6'h35, 8'h00, 1'b0, la);
    chk("perturbed_addr_untouched", bus.a_rdata, INIT_V);

    // Random mixed traffic over a small address window.
    for (int it = 0; it < 40; it++) begin
      m  = $urandom_range(1, 3);
      wa = 1'($urandom_range(0, 1));
      wb = 1'($urandom_range(0, 1));
      aa = 6'($urandom_range(0, 7));
      ab = 6'($urandom_range(0, 7));
      da = 8'($urandom);
      db = 8'($urandom);
      fork
        if (m[0]) xact(0, wa, aa, da, 1'b0, la);
        if (m[1]) xact(1, wb, ab, db, 1'b0, lb);
      join
    end

    // Reset during the RWAIT of a port-B read.
    @(negedge clk);
    base = ack_log.size();
    pend_we[1] = 1'b0; pend_addr[1] = 6'h05; pend_wd[1] = 8'h00;
    drive(1, 1'b1, 1'b0, 6'h05, 8'h00);
    @(negedge clk);  // ISSUE
    @(negedge clk);  // RWAIT
    rst_n = 1'b0;
    #1;
    chk("async_reset_ctl", {bus.a_ack, bus.b_ack, bus.mem_rd_en, bus.mem_wr_en, bus.init_done}, 0);
    chk("async_reset_data", {bus.a_rdata, bus.b_rdata, bus.mem_addr, bus.mem_wdata}, 0);
    drive(1, 1'b0, 1'b0, 6'h05, 8'h00);
    apply_reset();
    rst_n = 1'b1;
    check_init_sweep("reinit");
    chk("aborted_no_ack", ack_log.size() - base, 0);
    xact(1, 1'b0, 6'h05, 8'h00, 1'b0, lb);
    chk("post_reset_read", bus.b_rdata, INIT_V);

    chk("strobe_ack_overlap", overlap_cnt, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
